// File: rtl/dll_pkg.sv
// Shared definitions for the DLL lock controller.
//   dll_lock_state_t : controller FSM states
//   DLL_SEL_W/MAX/MIN: tap-select width and legal code range (code 0 is never driven)
package dll_pkg;

  localparam int                 DLL_SEL_W   = 7;
  localparam logic [DLL_SEL_W-1:0] DLL_SEL_MAX = 7'd127;
  localparam logic [DLL_SEL_W-1:0] DLL_SEL_MIN = 7'd1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    SEARCH_STEP,
    TRACK,
    ERR
  } dll_lock_state_t;

  // The delay line has no zero-tap setting; map 0 to the minimum code.
  function automatic logic [DLL_SEL_W-1:0] dll_sel_clamp(input logic [DLL_SEL_W-1:0] s);
    return (s == '0) ? DLL_SEL_MIN : s;
  endfunction

endpackage

// File: rtl/dll_pd_window.sv
// Phase-detector window evaluator.
// Synchronises the async phase-detector result, counts lag samples over a
// WIN_CYC-sample window and presents the majority verdict.
//   clk, rst     : clock, synchronous active-high reset
//   pd_lag       : async phase-detector input
//   clr          : clears window and lag counters (start of a new window)
//   en           : accumulate one synchronised sample this cycle
//   win_last     : combinational, high on the final sample cycle of a window
//   verdict_vld  : one-cycle strobe on the cycle after the final sample
//   verdict_lag  : window verdict, lag_cnt > WIN_CYC/2 (tie = not-lag)
module dll_pd_window #(
  parameter int WIN_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pd_lag,
  input  logic clr,
  input  logic en,
  output logic win_last,
  output logic verdict_vld,
  output logic verdict_lag
);

  localparam int CW = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
  localparam int LW = $clog2(WIN_CYC + 1);

  logic          pd_m, pd_s;
  logic [CW-1:0] win_cnt;
  logic [LW-1:0] lag_cnt;

  // 2-flop synchroniser; only pd_s is ever sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pd_m <= 1'b0;
      pd_s <= 1'b0;
    end else begin
      pd_m <= pd_lag;
      pd_s <= pd_m;
    end
  end

  assign win_last = en && (win_cnt == CW'(WIN_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_cnt <= '0;
      lag_cnt <= '0;
    end else if (en) begin
      win_cnt <= win_last ? '0 : win_cnt + CW'(1);
      lag_cnt <= lag_cnt + LW'(pd_s);
    end
  end

  // lag_cnt holds the full window total on the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) verdict_vld <= 1'b0;
    else     verdict_vld <= win_last;
  end

  assign verdict_lag = lag_cnt > LW'(WIN_CYC / 2);

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL lock controller: sweeps the 7-bit tap select upward from START_SEL,
// locks on the first window whose phase-detector verdict is "lag", then
// tracks drift with +/-1 steps after TRACK_VOTES same-direction windows.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_start       : restart calibration from START_SEL (any state)
//   i_pd_lag      : async phase-detector result (1 = too much delay)
//   o_sel_index   : tap select to the delay line (never 0)
//   o_locked      : high while tracking
//   o_lock_err    : sticky, search hit 127 without a lag verdict
//   o_busy        : high in SETTLE, SAMPLE, SEARCH_STEP
// Optional macro DLL_LOCK_CTRL_OVERRIDE_EN adds i_ovr_en / i_ovr_sel: a
// registered manual code override that freezes the FSM and drops o_locked;
// on release the FSM re-settles on the override code.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int WIN_CYC     = 16,
  parameter int TRACK_VOTES = 4,
  parameter int START_SEL   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_pd_lag,
`ifdef DLL_LOCK_CTRL_OVERRIDE_EN
  input  logic                 i_ovr_en,
  input  logic [DLL_SEL_W-1:0] i_ovr_sel,
`endif
  output logic [DLL_SEL_W-1:0] o_sel_index,
  output logic                 o_locked,
  output logic                 o_lock_err,
  output logic                 o_busy
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int VW = $clog2(TRACK_VOTES + 1);
  localparam logic [DLL_SEL_W-1:0] START_CODE = DLL_SEL_W'(START_SEL);

  dll_lock_state_t      state, state_n;
  logic [DLL_SEL_W-1:0] sel, sel_n;
  logic                 err, err_n;
  logic                 track_mode, track_n;
  logic [SW-1:0]        settle_cnt, settle_n;
  logic [VW-1:0]        vote_cnt, vote_n, vote_inc;
  logic                 vote_dir, vote_dir_n;

  logic settle_done, win_en, win_clr;
  logic win_last, verdict_vld, verdict_lag;
  logic frozen;

`ifdef DLL_LOCK_CTRL_OVERRIDE_EN
  logic ovr_q;
  assign frozen = i_ovr_en;
  always_ff @(posedge i_clk) begin
    if (i_rst) ovr_q <= 1'b0;
    else       ovr_q <= i_ovr_en;
  end
`else
  assign frozen = 1'b0;
`endif

  assign settle_done = (state == SETTLE) && (settle_cnt == SW'(SETTLE_CYC - 1));
  assign win_clr     = settle_done;
  assign win_en      = (state == SAMPLE) && !frozen;

  dll_pd_window #(.WIN_CYC(WIN_CYC)) u_win (
    .clk        (i_clk),
    .rst        (i_rst),
    .pd_lag     (i_pd_lag),
    .clr        (win_clr),
    .en         (win_en),
    .win_last   (win_last),
    .verdict_vld(verdict_vld),
    .verdict_lag(verdict_lag)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      sel        <= START_CODE;
      err        <= 1'b0;
      track_mode <= 1'b0;
      settle_cnt <= '0;
      vote_cnt   <= '0;
      vote_dir   <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      err        <= err_n;
      track_mode <= track_n;
      settle_cnt <= settle_n;
      vote_cnt   <= vote_n;
      vote_dir   <= vote_dir_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    err_n      = err;
    track_n    = track_mode;
    settle_n   = settle_cnt;
    vote_n     = vote_cnt;
    vote_dir_n = vote_dir;
    vote_inc   = '0;
`ifdef DLL_LOCK_CTRL_OVERRIDE_EN
    if (i_ovr_en) begin
      sel_n = dll_sel_clamp(i_ovr_sel);
    end else if (ovr_q) begin
      // release: re-settle around whatever code the override left behind
      state_n  = SETTLE;
      settle_n = '0;
    end else
`endif
    if (i_start) begin
      state_n    = SETTLE;
      sel_n      = START_CODE;
      err_n      = 1'b0;
      track_n    = 1'b0;
      settle_n   = '0;
      vote_n     = '0;
      vote_dir_n = 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_done) begin
            settle_n = '0;
            state_n  = SAMPLE;
          end else begin
            settle_n = settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          if (win_last) state_n = track_mode ? TRACK : SEARCH_STEP;
        end
        SEARCH_STEP: begin
          if (verdict_lag) begin
            track_n = 1'b1;
            vote_n  = '0;
            state_n = TRACK;
          end else if (sel == DLL_SEL_MAX) begin
            err_n   = 1'b1;
            state_n = ERR;
          end else begin
            sel_n   = sel + DLL_SEL_W'(1);
            state_n = SETTLE;
          end
        end
        TRACK: begin
          // Entered either right after lock (no fresh verdict) or after a
          // tracking window (verdict strobe present).
          state_n = SETTLE;
          if (verdict_vld) begin
            vote_inc   = (vote_cnt != '0 && vote_dir == verdict_lag) ? vote_cnt + VW'(1) : VW'(1);
            vote_dir_n = verdict_lag;
            if (vote_inc == VW'(TRACK_VOTES)) begin
              vote_n = '0;
              if (verdict_lag && sel != DLL_SEL_MIN)       sel_n = sel - DLL_SEL_W'(1);
              else if (!verdict_lag && sel != DLL_SEL_MAX) sel_n = sel + DLL_SEL_W'(1);
            end else begin
              vote_n = vote_inc;
            end
          end
        end
        IDLE, ERR: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign o_sel_index = sel;
  assign o_lock_err  = err;
  assign o_busy      = (state == SETTLE) || (state == SAMPLE) || (state == SEARCH_STEP);
`ifdef DLL_LOCK_CTRL_OVERRIDE_EN
  assign o_locked    = track_mode && !ovr_q;
`else
  assign o_locked    = track_mode;
`endif

endmodule

// File: doc/dll_lock_ctrl.md
Name: dll_lock_ctrl

Overview:
- Calibration/tracking controller that drives the 7-bit tap select of the 128-tap DLL delay line.
- Sweeps the select code, samples a phase-detector result comparing the delay-line output against the reference, declares lock at the first lag transition, then tracks drift with filtered ±1 steps.
- Sits directly upstream of the delay line.
- Its o_sel_index feeds the delay line's sel_index; the delay line's output returns via an external phase detector as i_pd_lag.

Parameters:
- SETTLE_CYC, 8: cycles waited after any select change before sampling starts.
- WIN_CYC, 16: phase-detector samples per evaluation window (power of two, ≥2).
- TRACK_VOTES, 4: consecutive same-direction windows needed for a tracking step.
- START_SEL, 1: select code loaded at search start (1..127).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  one-cycle pulse; (re)starts calibration from START_SEL.
- i_pd_lag  input  1  async phase-detector result; 1 = delayed clock lags the reference (too much delay).
- o_sel_index  output  7  tap select to the delay line.
- o_locked  output  1  high while in TRACK.
- o_lock_err  output  1  sticky; set when the search reaches 127 without a lag transition.
- o_busy  output  1  high in SETTLE, SAMPLE or SEARCH_STEP.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_sel_index=START_SEL, o_locked=0, o_lock_err=0, o_busy=0, state=IDLE, all counters 0.
- i_rst has priority over everything. Asserting it mid-search or mid-track returns all outputs to reset values on the next edge.
- Synchroniser: i_pd_lag passes through a 2-flop synchroniser (pd_s). Sampling uses pd_s only. Input-to-use latency is 2 cycles.
- States: IDLE, SETTLE, SAMPLE, SEARCH_STEP, TRACK, ERR.
- IDLE:
  - i_start -> o_sel_index=START_SEL, clear o_lock_err, enter SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles, then clears lag_cnt and enters SAMPLE.
- SAMPLE:
  - Accumulates pd_s into lag_cnt for exactly WIN_CYC cycles.
  - Window verdict: lag = (lag_cnt > WIN_CYC/2). A tie counts as not-lag.
  - Verdict is consumed on the cycle after the last sample.
  - During search, goes to SEARCH_STEP. During tracking (track_mode=1), returns to TRACK.
- SEARCH_STEP (one cycle):
  - Verdict lag=1 -> lock: hold the current code, set track_mode, o_locked=1, enter TRACK.
  - Verdict lag=0 and o_sel_index<127 -> increment, enter SETTLE.
  - Verdict lag=0 and o_sel_index==127 -> o_lock_err=1, enter ERR.
- TRACK:
  - Runs windows continuously as SETTLE→SAMPLE→TRACK. o_locked stays 1 throughout.
  - Consecutive verdicts of the same direction increment vote_cnt; a direction change reloads vote_cnt to 1.
  - When vote_cnt reaches TRACK_VOTES: lag → decrement, not-lag → increment, then vote_cnt=0.
  - Saturate at 1 and 127. No wrap-around, no step at the limits, and vote_cnt still clears.
  - A code step restarts SETTLE before the next window.
- ERR:
  - Holds o_sel_index=127 and o_lock_err=1 until i_start or i_rst.
- i_start in any non-IDLE state restarts the search (same as from IDLE) and clears o_locked and track_mode on the next edge.
- i_start simultaneous with the verdict cycle: i_start wins.
- o_sel_index never takes the value 0 (the delay line's minimum is 1 tap) and changes by at most 1 per step, except on restart.

Optional Feature:
- Macro: DLL_LOCK_CTRL_OVERRIDE_EN.
- When defined, two extra inputs are added: i_ovr_en (1) and i_ovr_sel (7).
  - While i_ovr_en=1, o_sel_index=i_ovr_sel registered (1-cycle latency), with 0 mapped to 1.
  - The FSM is frozen in its current state, counters hold, and o_locked is forced to 0.
  - On deassertion the FSM resumes SETTLE with the override value as the current code.
- When not defined, the ports are absent and no override logic is present.

Decomposition:
- Shared package dll_pkg:
  - state enum dll_lock_state_t.
  - DLL_SEL_W=7, DLL_SEL_MAX=127, DLL_SEL_MIN=1.
- One natural sub-module: dll_pd_window, holding the 2-flop synchroniser, window counter, lag accumulator and verdict strobe.
- FSM, select register and vote logic live in the top.

Test Plan:
- Reset then i_start, i_pd_lag tied 0 until o_sel_index=40, then tied 1 -> sweep 1..40, o_locked=1 with o_sel_index=40. Each step takes SETTLE_CYC+WIN_CYC+1 = 25 cycles.
- i_pd_lag constantly 0 -> code reaches 127, o_lock_err=1, state ERR. A subsequent i_start clears the error and restarts at 1.
- Locked at 60, then i_pd_lag=1 for 4 windows -> o_sel_index=59. Alternate lag and no-lag windows -> no change.
- Locked at 127, then 4 no-lag windows -> code stays 127. Locked at 1, then 4 lag windows -> stays 1.
- Window of exactly 8/16 lag samples -> treated as not-lag, search continues.
- i_rst asserted mid-SAMPLE at code 33 -> next edge o_sel_index=1, o_locked=0, o_busy=0. Also: i_start during TRACK -> restart from 1.
